alu_cmd_driver: RTL
===================

# alu_cmd_driver

Command-side front end for the scalar ALU. It accepts tagged ALU commands over a valid/ready handshake and drives `op_code`, `scalar_a` and `scalar_b` into the ALU, holding them stable. After the ALU's fixed registered latency it captures `alu_out` and returns the result with its tag over a second valid/ready handshake. It sits between the issue logic (sequencer or testbench host) and the free-running ALU, and keeps at most one command in flight.

## Interface
Parameters:
- DATA_IN_WIDTH, 32, operand width; must match the ALU.
- OP_CODE_WIDTH, 4, opcode width; must match the ALU.
- DATA_OUT_WIDTH, 64, result width; must match the ALU.
- ALU_LATENCY, 1, number of clock edges from the ALU sampling its inputs to `alu_out` being valid; ≥1.
- TAG_WIDTH, 4, width of the command tag.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver can accept a command.
- cmd_op  in  OP_CODE_WIDTH  ALU opcode.
- cmd_a, cmd_b  in  DATA_IN_WIDTH  operands.
- cmd_tag  in  TAG_WIDTH  opaque tag, echoed in the response.
- alu_op_code  out  OP_CODE_WIDTH  to ALU `op_code`.
- alu_scalar_a, alu_scalar_b  out  DATA_IN_WIDTH  to ALU operands.
- alu_result  in  DATA_OUT_WIDTH  from ALU `alu_out`.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_OUT_WIDTH  captured ALU result.
- rsp_tag  out  TAG_WIDTH  tag of the completed command.
- rsp_div_zero  out  1  the command was a divide (4'b0011) with `cmd_b == 0`.
- ops_done  out  16  count of completed response handshakes; wraps.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `cmd_ready = 1`. When `cmd_valid` is high, register `cmd_op/a/b` into the `alu_*` outputs and latch the tag and the div-zero flag. Load `lat_cnt <= ALU_LATENCY` and go to WAIT.
  - WAIT: on each edge, if `lat_cnt == 0`, capture `alu_result` into `rsp_data` and go to RESP; otherwise decrement `lat_cnt`.
  - RESP: `rsp_valid = 1`. When `rsp_ready` is high, increment `ops_done` and go to IDLE.
- `cmd_ready` is high only in IDLE, driven combinationally from the state. Command fields are sampled only on the handshake edge.
- `alu_*` outputs are registered. They hold the last accepted command until the next accept, so the ALU output stays stable during WAIT and RESP.
- `rsp_data`, `rsp_tag` and `rsp_div_zero` are registered and stable while `rsp_valid && !rsp_ready`.
- `lat_cnt` width is `$clog2(ALU_LATENCY+1)`.
- `ops_done` wraps from 16'hFFFF to 0.
- No arithmetic is performed in this block; results pass through unchanged. Divide-by-zero returns whatever the ALU produces (zero), flagged by `rsp_div_zero`.

## Timing
- Reset values: `cmd_ready` 1 (state IDLE), `rsp_valid` 0, `alu_op_code` 0, `alu_scalar_a` 0, `alu_scalar_b` 0, `rsp_data` 0, `rsp_tag` 0, `rsp_div_zero` 0, `ops_done` 0, `lat_cnt` 0.
- Edge E0 is the accept edge. The ALU samples operands at E1, `alu_result` is valid after E(ALU_LATENCY), and the driver captures at E(ALU_LATENCY+1). `rsp_valid` rises ALU_LATENCY+1 cycles after the accept.
- With zero backpressure, the minimum command spacing is ALU_LATENCY+3 cycles: accept, L+1 cycles of WAIT, 1 cycle of RESP, then back to IDLE.
- `rsp_ready` high before `rsp_valid` has no effect. The handshake completes on the first edge with both high.
- `cmd_valid` outside IDLE is ignored; the command is not lost, because the producer must hold it until ready.
- Reset mid-operation (in WAIT or RESP) drops the in-flight command: no response is issued, `ops_done` is not incremented, and the block is in IDLE on the next cycle.
- Reset takes priority over any simultaneous handshake.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode enum: ALU_ADD 0000, ALU_SUB 0001, ALU_MUL 0010, ALU_DIV 0011, ALU_SLL_A 0100, ALU_SRL_A 0101, ALU_SLL_B 0110, ALU_SRL_B 0111, ALU_AND 1000, ALU_OR 1001, ALU_XOR 1010, ALU_NAND 1011, ALU_NOR 1100, ALU_XNOR 1101, ALU_GT 1110, ALU_LT 1111;
  - the default width constants;
  - the FSM state typedef.
- No sub-module is needed; the FSM, latency counter and response registers sit in one module. The bench pairs this block with the ALU.

## Test plan
- Reset: assert `rst` for 2 cycles, then release → `cmd_ready=1`, `rsp_valid=0`, `alu_op_code=0`, `ops_done=0`.
- ADD, a=5, b=7, tag=3, `rsp_ready` tied high, ALU_LATENCY=1 → `rsp_valid` exactly 2 cycles after accept, `rsp_data=12`, `rsp_tag=3`, `rsp_div_zero=0`, `ops_done=1`.
- DIV 100/7 → `rsp_data=14`, `rsp_div_zero=0`. Then DIV 100/0 → `rsp_data=0`, `rsp_div_zero=1`.
- SUB 9−4 with `rsp_ready` held low for 5 cycles, and a second command held valid throughout → `rsp_data` stays 5, `cmd_ready` stays 0. The second command is accepted on the cycle after the response handshake.
- Reset asserted during WAIT of an OR, a=0xF0, b=0x0F → no `rsp_valid`, `cmd_ready=1` the next cycle, `ops_done` unchanged.
- Rebuild with ALU_LATENCY=3 and issue LT, a=2, b=9 → `rsp_valid` 4 cycles after accept, `rsp_data` all ones.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, default widths and the command driver FSM states.
package alu_pkg;

    localparam int DEF_DATA_IN_WIDTH  = 32;
    localparam int DEF_OP_CODE_WIDTH  = 4;
    localparam int DEF_DATA_OUT_WIDTH = 64;
    localparam int DEF_ALU_LATENCY    = 1;
    localparam int DEF_TAG_WIDTH      = 4;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_MUL   = 4'b0010,
        ALU_DIV   = 4'b0011,
        ALU_SLL_A = 4'b0100,
        ALU_SRL_A = 4'b0101,
        ALU_SLL_B = 4'b0110,
        ALU_SRL_B = 4'b0111,
        ALU_AND   = 4'b1000,
        ALU_OR    = 4'b1001,
        ALU_XOR   = 4'b1010,
        ALU_NAND  = 4'b1011,
        ALU_NOR   = 4'b1100,
        ALU_XNOR  = 4'b1101,
        ALU_GT    = 4'b1110,
        ALU_LT    = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } drv_state_e;

endpackage

// File: rtl/alu_cmd_driver.sv
// Command front end for the scalar ALU: holds one command on the ALU inputs, waits out the
// ALU's registered latency, then returns the captured result with its tag.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
    parameter int OP_CODE_WIDTH  = DEF_OP_CODE_WIDTH,
    parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
    parameter int ALU_LATENCY    = DEF_ALU_LATENCY,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [OP_CODE_WIDTH-1:0]  cmd_op,
    input  logic [DATA_IN_WIDTH-1:0]  cmd_a,
    input  logic [DATA_IN_WIDTH-1:0]  cmd_b,
    input  logic [TAG_WIDTH-1:0]      cmd_tag,
    output logic [OP_CODE_WIDTH-1:0]  alu_op_code,
    output logic [DATA_IN_WIDTH-1:0]  alu_scalar_a,
    output logic [DATA_IN_WIDTH-1:0]  alu_scalar_b,
    input  logic [DATA_OUT_WIDTH-1:0] alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_OUT_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]      rsp_tag,
    output logic                      rsp_div_zero,
    output logic [15:0]               ops_done
);

    localparam int LAT_W = $clog2(ALU_LATENCY + 1);

    drv_state_e       state, state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic             cmd_fire;
    logic             rsp_fire;
    logic             lat_done;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign lat_done = (state == WAIT) && (lat_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU inputs only change on accept, so alu_result is stable through WAIT and RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_code  <= '0;
            alu_scalar_a <= '0;
            alu_scalar_b <= '0;
            rsp_tag      <= '0;
            rsp_div_zero <= 1'b0;
            lat_cnt      <= '0;
        end else if (cmd_fire) begin
            alu_op_code  <= cmd_op;
            alu_scalar_a <= cmd_a;
            alu_scalar_b <= cmd_b;
            rsp_tag      <= cmd_tag;
            rsp_div_zero <= (cmd_op == OP_CODE_WIDTH'(ALU_DIV)) && (cmd_b == '0);
            lat_cnt      <= LAT_W'(ALU_LATENCY);
        end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            ops_done <= '0;
        end else begin
            if (lat_done) rsp_data <= alu_result;
            if (rsp_fire) ops_done <= ops_done + 16'd1;
        end
    end

endmodule
